// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC operation codes and default vectors shared by the
// program-counter unit, its return-address stack and the testbench.
package pc_unit_pkg;

  // Next-PC operation codes driven by decode/control (3 bits).
  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JAL    = 3'b011;
  localparam logic [2:0] NPC_JR     = 3'b100;
  localparam logic [2:0] NPC_RET    = 3'b101;

  // Default reset vector and misaligned-indirect-jump redirect target.
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack. r_ptr addresses the next slot to
// write, so the top entry lives at r_ptr-1. A push when full lands on the
// oldest entry (which is exactly the slot at r_ptr) and the count saturates.
// Push wins if push and pop are both requested; i_hold freezes everything.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_hold,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_push_data,
  output logic [WIDTH-1:0]             o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_count
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !i_hold;
  assign w_do_pop  = i_pop && !i_hold && !i_push && (r_count != '0);
  assign w_top_idx = r_ptr - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_count   = r_count;

  // Pointer and occupancy: reset clears, push advances/saturates, pop retreats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_ptr   <= r_ptr + PW'(1);
      r_count <= (r_count == FULL) ? FULL : r_count + CW'(1);
    end else if (w_do_pop) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  // Entry storage: written only on a committed push, contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_do_push) begin
      r_mem[r_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: architectural PC register plus next-PC selection for the fetch
// stage. npc is combinational and commits at the next edge unless stalled.
// JAL pushes pc+4 onto the return-address stack; RET pops it, or falls back
// to rs_data with a one-cycle ras_miss pulse when the stack is empty.
// Optional build macro PC_ALIGN_CHK_EN: JR and RET-fallback targets with
// nonzero low bits are redirected to EXC_VECTOR and raise a one-cycle
// align_err pulse. EXC_VECTOR exists only in that build.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          RAS_DEPTH = 4
`ifdef PC_ALIGN_CHK_EN
  ,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic [2:0]                 i_npc_op,
  input  logic [25:0]                i_imm,
  input  logic [WIDTH-1:0]           i_rs_data,
  output logic [WIDTH-1:0]           o_pc,
  output logic [WIDTH-1:0]           o_pc_plus4,
  output logic [WIDTH-1:0]           o_npc,
  output logic [$clog2(RAS_DEPTH):0] o_ras_count,
  output logic                       o_ras_miss,
  output logic                       o_align_err
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;
  // Low 28 bits are replaced by {index, 2'b00} on a jump.
  localparam logic [WIDTH-1:0] LO28_MASK = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] r_pc;
  logic             r_ras_miss;
  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_branch_off;
  logic [WIDTH-1:0] w_jump_tgt;
  logic [WIDTH-1:0] w_ras_top;
  logic [CW-1:0]    w_ras_count;
  logic             w_ras_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_ret_miss;
  logic [WIDTH-1:0] w_npc;

  assign w_pc_plus4   = r_pc + WIDTH'(4);
  assign w_branch_off = {{(WIDTH-18){i_imm[15]}}, i_imm[15:0], 2'b00};
  assign w_jump_tgt   = (w_pc_plus4 & ~LO28_MASK) | WIDTH'({i_imm, 2'b00});
  assign w_ras_empty  = (w_ras_count == '0);

  // Target mux: raw next PC and the stack operation implied by the op.
  always_comb begin
    w_npc      = w_pc_plus4;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    w_ret_miss = 1'b0;
    case (i_npc_op)
      NPC_BRANCH: w_npc = w_pc_plus4 + w_branch_off;
      NPC_JUMP:   w_npc = w_jump_tgt;
      NPC_JAL: begin
        w_npc  = w_jump_tgt;
        w_push = 1'b1;
      end
      NPC_JR:     w_npc = i_rs_data;
      NPC_RET: begin
        if (!w_ras_empty) begin
          w_npc = w_ras_top;
          w_pop = 1'b1;
        end else begin
          w_npc      = i_rs_data;
          w_ret_miss = 1'b1;
        end
      end
      default:    w_npc = w_pc_plus4;
    endcase
  end

`ifdef PC_ALIGN_CHK_EN
  logic w_misalign;
  logic r_align_err;

  // Only register-sourced targets are checked; a RAS hit is trusted.
  assign w_misalign  = ((i_npc_op == NPC_JR) || w_ret_miss) && (i_rs_data[1:0] != 2'b00);
  assign o_npc       = w_misalign ? WIDTH'(EXC_VECTOR) : w_npc;
  assign o_align_err = r_align_err;

  // Alignment error pulse: one cycle after a committed misaligned jump.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stall) begin
      r_align_err <= 1'b0;
    end else begin
      r_align_err <= w_misalign;
    end
  end
`else
  assign o_npc       = w_npc;
  assign o_align_err = 1'b0;
`endif

  // PC register: reset has priority, stall holds, otherwise commit npc.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= WIDTH'(RESET_PC);
    end else if (!i_stall) begin
      r_pc <= o_npc;
    end
  end

  // RAS miss pulse: one cycle after a committed RET on an empty stack.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_stall) begin
      r_ras_miss <= 1'b0;
    end else begin
      r_ras_miss <= w_ret_miss;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (i_clk),
    .rst         (i_rst),
    .i_hold      (i_stall),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_plus4),
    .o_top       (w_ras_top),
    .o_count     (w_ras_count)
  );

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_ras_count = w_ras_count;
  assign o_ras_miss  = r_ras_miss;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors, hand sequences and random ops for pc_unit,
// checked against a queue-based reference model of PC and return stack.
module tb_pc_unit;
  import pc_unit_pkg::*;

  localparam int RAS_DEPTH = 4;
  localparam logic [31:0] EXC = 32'h0000_4180;

  logic        clk;
  logic        i_rst;
  logic        i_stall;
  logic [2:0]  i_npc_op;
  logic [25:0] i_imm;
  logic [31:0] i_rs_data;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_npc;
  logic [2:0]  o_ras_count;
  logic        o_ras_miss;
  logic        o_align_err;

  pc_unit #(.WIDTH(32), .RESET_PC(32'h0), .RAS_DEPTH(RAS_DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_stall     (i_stall),
    .i_npc_op    (i_npc_op),
    .i_imm       (i_imm),
    .i_rs_data   (i_rs_data),
    .o_pc        (o_pc),
    .o_pc_plus4  (o_pc_plus4),
    .o_npc       (o_npc),
    .o_ras_count (o_ras_count),
    .o_ras_miss  (o_ras_miss),
    .o_align_err (o_align_err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: PC and return stack as a queue (back = top).
  logic [31:0] m_pc = 32'h0;
  logic [31:0] ras_q[$];

  function automatic bit align_on();
`ifdef PC_ALIGN_CHK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_target(input logic [31:0] rs);
    if (align_on() && rs[1:0] != 2'b00) return EXC;
    return rs;
  endfunction

  function automatic logic [31:0] model_npc(input logic [2:0] op, input logic [25:0] imm,
                                            input logic [31:0] rs);
    logic [31:0] p4;
    int off;
    p4  = m_pc + 32'd4;
    off = $signed(imm[15:0]) * 4;
    case (op)
      NPC_BRANCH: return p4 + 32'(off);
      NPC_JUMP, NPC_JAL: return (p4 & 32'hF000_0000) | ({6'b0, imm} << 2);
      NPC_JR: return reg_target(rs);
      NPC_RET: begin
        if (ras_q.size() > 0) return ras_q[$];
        return reg_target(rs);
      end
      default: return p4;
    endcase
  endfunction

  // Driver: apply one cycle of inputs, check npc before the edge and all
  // registered outputs after it against the model.
  task automatic cycle(input logic r, input logic s, input logic [2:0] op,
                       input logic [25:0] imm, input logic [31:0] rs);
    logic [31:0] e_npc;
    logic e_miss, e_align;
    i_rst = r; i_stall = s; i_npc_op = op; i_imm = imm; i_rs_data = rs;
    #1;
    e_npc = model_npc(op, imm, rs);
    check("npc", o_npc, e_npc);
    check("pc_plus4", o_pc_plus4, m_pc + 32'd4);
    @(posedge clk);
    e_miss = 1'b0;
    e_align = 1'b0;
    if (r) begin
      m_pc = 32'h0;
      ras_q.delete();
    end else if (!s) begin
      e_miss = (op == NPC_RET) && (ras_q.size() == 0);
      e_align = align_on() && ((op == NPC_JR) || e_miss) && (rs[1:0] != 2'b00);
      if (op == NPC_JAL) begin
        ras_q.push_back(m_pc + 32'd4);
        if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
      end else if (op == NPC_RET && ras_q.size() > 0) begin
        void'(ras_q.pop_back());
      end
      m_pc = e_npc;
    end
    #1;
    check("pc", o_pc, m_pc);
    check("ras_count", 32'(o_ras_count), 32'(ras_q.size()));
    check("ras_miss", 32'(o_ras_miss), 32'(e_miss));
    check("align_err", 32'(o_align_err), 32'(e_align));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [25:0] imm;
    logic [31:0] rs;
    logic [31:0] exp_npc;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Directed npc vectors, all applied from pc=0x100 with stall held.
    vecs[0] = '{NPC_PLUS4,  26'h0,      32'h0,      32'h0000_0104};
    vecs[1] = '{NPC_BRANCH, 26'hFFFE,   32'h0,      32'h0000_00FC};
    vecs[2] = '{NPC_BRANCH, 26'h0003,   32'h0,      32'h0000_0110};
    vecs[3] = '{NPC_BRANCH, 26'h8000,   32'h0,      32'hFFFE_0104};
    vecs[4] = '{NPC_JUMP,   26'h40,     32'h0,      32'h0000_0100};
    vecs[5] = '{NPC_JR,     26'h0,      32'h2000,   32'h0000_2000};
    vecs[6] = '{NPC_RET,    26'h0,      32'h800,    32'h0000_0800};
    vecs[7] = '{3'b110,     26'h3FFFFFF, 32'h1234,  32'h0000_0104};
    vecs[8] = '{3'b111,     26'h0,      32'h5678,   32'h0000_0104};

    i_rst = 1'b1; i_stall = 1'b0; i_npc_op = NPC_PLUS4; i_imm = '0; i_rs_data = '0;
    @(posedge clk);
    #1;

    // Reset state and sequential fetch.
    cycle(1, 0, NPC_PLUS4, 0, 0);
    check("reset_pc", o_pc, 32'h0);
    check("reset_ras_count", 32'(o_ras_count), 32'h0);
    check("reset_ras_miss", 32'(o_ras_miss), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 0, NPC_PLUS4, 0, 0);
      check("plus4_seq", o_pc, 32'(4 * i));
    end

    // Table-driven npc vectors.
    cycle(0, 0, NPC_JR, 0, 32'h100);
    for (int i = 0; i < 9; i++) begin
      i_rst = 0; i_stall = 1; i_npc_op = vecs[i].op; i_imm = vecs[i].imm; i_rs_data = vecs[i].rs;
      #1;
      check("vec_npc", o_npc, vecs[i].exp_npc);
      cycle(0, 1, vecs[i].op, vecs[i].imm, vecs[i].rs);
      check("vec_hold_pc", o_pc, 32'h100);
    end

    // Call and return across the high-bit region.
    cycle(0, 0, NPC_JR, 0, 32'h3000_0010);
    cycle(0, 0, NPC_JAL, 26'h40, 0);
    check("jal_pc", o_pc, 32'h3000_0100);
    check("jal_count", 32'(o_ras_count), 32'h1);
    cycle(0, 0, NPC_RET, 0, 32'hDEAD_0000);
    check("ret_pc", o_pc, 32'h3000_0014);
    check("ret_count", 32'(o_ras_count), 32'h0);

    // Overflow: five calls into a four-entry stack, then five returns.
    cycle(0, 0, NPC_JR, 0, 32'h0);
    cycle(0, 0, NPC_JAL, 26'h40, 0);
    cycle(0, 0, NPC_JAL, 26'h80, 0);
    cycle(0, 0, NPC_JAL, 26'hC0, 0);
    cycle(0, 0, NPC_JAL, 26'h100, 0);
    cycle(0, 0, NPC_JAL, 26'h400, 0);
    check("ovf_pc", o_pc, 32'h1000);
    check("ovf_count", 32'(o_ras_count), 32'h4);
    cycle(0, 0, NPC_RET, 0, 32'h800);
    check("ret1", o_pc, 32'h404);
    cycle(0, 0, NPC_RET, 0, 32'h800);
    check("ret2", o_pc, 32'h304);
    cycle(0, 0, NPC_RET, 0, 32'h800);
    check("ret3", o_pc, 32'h204);
    cycle(0, 0, NPC_RET, 0, 32'h800);
    check("ret4", o_pc, 32'h104);
    cycle(0, 0, NPC_RET, 0, 32'h800);
    check("ret5_pc", o_pc, 32'h800);
    check("ret5_miss", 32'(o_ras_miss), 32'h1);
    cycle(0, 0, NPC_PLUS4, 0, 0);
    check("miss_clears", 32'(o_ras_miss), 32'h0);

    // Stall during JAL, then reset while stalled.
    cycle(0, 0, NPC_JR, 0, 32'h500);
    cycle(0, 1, NPC_JAL, 26'h200, 0);
    check("stall1_pc", o_pc, 32'h500);
    check("stall1_count", 32'(o_ras_count), 32'h0);
    cycle(0, 1, NPC_JAL, 26'h200, 0);
    check("stall2_pc", o_pc, 32'h500);
    cycle(0, 0, NPC_JAL, 26'h200, 0);
    check("unstall_pc", o_pc, 32'h800);
    check("unstall_count", 32'(o_ras_count), 32'h1);
    cycle(1, 1, NPC_JAL, 26'h300, 0);
    check("rst_stall_pc", o_pc, 32'h0);
    check("rst_stall_count", 32'(o_ras_count), 32'h0);

    // Misaligned indirect jump.
    cycle(0, 0, NPC_JR, 0, 32'h102);
    check("jr_mis_pc", o_pc, align_on() ? EXC : 32'h102);
    check("jr_mis_err", 32'(o_align_err), align_on() ? 32'h1 : 32'h0);
    cycle(0, 0, NPC_PLUS4, 0, 0);
    check("align_err_clears", 32'(o_align_err), 32'h0);

    // Wrap from the top of the address space.
    cycle(0, 0, NPC_JR, 0, 32'hFFFF_FFFC);
    cycle(0, 0, NPC_PLUS4, 0, 0);
    check("wrap_pc", o_pc, 32'h0);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  op;
      logic [31:0] rs;
      op = 3'($urandom_range(0, 7));
      rs = $urandom();
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), op,
            26'($urandom()), rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit: holds the architectural PC register and computes and commits the next PC every cycle.
- Generalises the combinational next-PC logic with:
  - configurable width and reset vector;
  - a stall hold;
  - register-indirect jumps;
  - a circular return-address stack (RAS) for call/return prediction.
- Sits at the head of the fetch stage; drives the instruction-memory address. Decode/control supplies the op and operands.

Parameters:
- WIDTH, 32, PC and data width in bits (>= 28).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH).
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2).
- EXC_VECTOR, 32'h0000_4180, redirect target for misaligned indirect jumps (used only with PC_ALIGN_CHK_EN).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC and RAS this cycle
- npc_op  in  3  next-PC operation (encoding in package)
- imm  in  26  instruction immediate; [15:0] branch offset, [25:0] jump index
- rs_data  in  WIDTH  register operand for JR / RET fallback
- pc  out  WIDTH  current PC (registered)
- pc_plus4  out  WIDTH  pc + 4 (combinational)
- npc  out  WIDTH  next PC that commits at the next edge if not stalled (combinational)
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_miss  out  1  registered one-cycle pulse: RET committed with empty RAS
- align_err  out  1  registered one-cycle pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset (sync, at clk edge with rst=1):
  - pc=RESET_PC, ras_count=0, ras_miss=0, align_err=0, RAS pointer=0.
  - rst has priority over stall and npc_op.
  - Reset mid-call-sequence discards all RAS contents.
- npc_op encodings:
  - PLUS4 (000): npc = pc+4.
  - BRANCH (001): npc = pc+4 + (sign-extend(imm[15:0]) << 2). Taken/not-taken is resolved upstream; not-taken arrives as PLUS4.
  - JUMP (010): npc = {pc_plus4[WIDTH-1:28], imm[25:0], 2'b00}.
  - JAL (011): npc as JUMP; push pc+4 onto RAS.
  - JR (100): npc = rs_data.
  - RET (101): if ras_count>0, npc = top of RAS and pop; else npc = rs_data and ras_miss pulses next cycle.
  - 110/111: treated as PLUS4, no RAS effect.
- Commit: at each edge with rst=0 and stall=0, pc <= npc and the RAS update is applied. With stall=1, pc, RAS, ras_count and pointer hold; pulses clear.
- All arithmetic is modulo 2^WIDTH; pc wrap from all-ones-minus-3 to 0 is legal, no flag.
- RAS: circular buffer with top pointer.
  - Push when full overwrites the oldest entry; ras_count saturates at RAS_DEPTH.
  - Pop decrements the pointer modulo RAS_DEPTH and decrements ras_count.
  - Only one push or pop occurs per cycle (single op).
- Latency: npc is valid combinationally in the same cycle; pc reflects it one cycle later.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - For JR and for RET-fallback, if target[1:0]!=2'b00, npc = EXC_VECTOR and align_err pulses for one cycle after commit.
  - A RET with a RAS hit is never checked.
  - A stalled cycle raises no error.
- Undefined: targets pass through unmodified; align_err tied 0.

Decomposition:
- Shared package/include holds:
  - NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JAL, NPC_JR, NPC_RET op constants (3-bit);
  - default RESET_PC and EXC_VECTOR constants.
- Sub-module pc_ras: the RAS storage, pointer and count, with push/pop/hold ports. It is parametrised by WIDTH and RAS_DEPTH.
- The top module holds the PC register, the target mux and the pulse flops.

Test Plan:
- Reset then 3 cycles of PLUS4 -> pc 0x0, 0x4, 0x8, 0xC; ras_count=0.
- pc=0x100, BRANCH imm[15:0]=16'hFFFE -> npc=0xFC; with imm=16'h0003 -> npc=0x110.
- pc=0x3000_0010, JAL imm=26'h0000040 -> pc=0x3000_0100, ras_count=1. Then RET -> pc=0x3000_0014, ras_count=0.
- RAS_DEPTH=4: push 5 JALs from pc 0x0, 0x100, 0x200, 0x300, 0x400, then 5 RETs. Expect:
  - returns 0x404, 0x304, 0x204, 0x104;
  - 5th RET uses rs_data=0x800 with a ras_miss pulse;
  - ras_count stays 4 after the 5th push.
- Stall held 2 cycles during JAL -> pc and ras_count unchanged until stall drops, then exactly one push. Also: rst asserted during stall -> pc=RESET_PC next edge.
- With PC_ALIGN_CHK_EN: JR rs_data=0x102 -> pc=EXC_VECTOR, align_err=1 for exactly one cycle. Without the macro: pc=0x102, align_err=0.
